// File: rtl/hmac_block_driver.sv
// hmac_block_driver
//   Host-side initiator for an HMAC-384 core. Packs a stream of host words into one
//   pre-padded block, latches the key on the first word of a new message, launches the
//   core with a single init or next pulse and captures the resulting tag.
//
// Ports
//   clk, reset      clock and asynchronous active-high reset
//   key_in          key, sampled with word 0 of a block that starts a new message
//   blk_first       qualifies word 0: the block starts a new message
//   word_valid      host word valid
//   word_ready      driver can accept a word (only while filling)
//   word_data       host word; the first word of a block lands in the block MSW
//   clear           drops a partially filled block (cursor back to word 0)
//   busy            block launched and its tag not yet captured
//   tag_o           last captured tag
//   tag_valid_o     one-cycle pulse, tag_o was just updated
//   core_init       one-cycle launch of the first block of a message
//   core_next       one-cycle launch of a continuation block
//   core_ready      core can take a launch
//   core_tag_valid  core tag valid (level, held until the core is relaunched)
//   core_key        key to the core, stable while busy
//   core_block      block to the core, stable while busy
//   core_tag        tag from the core

module hmac_block_driver #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 1024,
    parameter int unsigned KEY_W   = 384,
    parameter int unsigned TAG_W   = 384
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               blk_first,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               clear,
    output logic               busy,
    output logic [TAG_W-1:0]   tag_o,
    output logic               tag_valid_o,
    output logic               core_init,
    output logic               core_next,
    input  logic               core_ready,
    input  logic               core_tag_valid,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_block,
    input  logic [TAG_W-1:0]   core_tag
);

    localparam int unsigned WORDS = BLOCK_W / WORD_W;
    localparam int unsigned CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        StFill,
        StLaunch,
        StWaitClr,
        StWaitTag
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_init_q;
    logic             first_ever_q;

    logic accept;
    logic last_word;
    logic new_msg;
    logic launch;
    logic capture;

    // clear has priority over an accept in the same cycle: the word is dropped.
    assign accept    = (state_q == StFill) && word_valid && !clear;
    assign last_word = accept && (cnt_q == CNT_W'(WORDS - 1));
    assign new_msg   = blk_first || first_ever_q;
    assign launch    = (state_q == StLaunch) && core_ready;
    assign capture   = (state_q == StWaitTag) && core_tag_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (last_word) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                if (core_ready) begin
                    state_d = StWaitClr;
                end
            end
            // The core holds tag_valid from the previous block until it notices the
            // relaunch; waiting for it to drop keeps that stale tag from being captured.
            StWaitClr: begin
                if (!core_tag_valid) begin
                    state_d = StWaitTag;
                end
            end
            StWaitTag: begin
                if (core_tag_valid) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        word_ready = 1'b0;
        busy       = 1'b0;
        core_init  = 1'b0;
        core_next  = 1'b0;
        unique case (state_q)
            StFill: begin
                word_ready = 1'b1;
            end
            StLaunch: begin
                busy      = 1'b1;
                core_init = core_ready && mode_init_q;
                core_next = core_ready && !mode_init_q;
            end
            StWaitClr, StWaitTag: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word cursor
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StFill) begin
            if (clear) begin
                cnt_d = '0;
            end else if (last_word) begin
                cnt_d = '0;
            end else if (accept) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Block assembly: word k of the block sits at the k-th word from the top.
    // A clear only rewinds the cursor; stale bits are overwritten on refill.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_block <= '0;
        end else if (accept) begin
            for (int k = 0; k < WORDS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    core_block[BLOCK_W-1-WORD_W*k -: WORD_W] <= word_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Launch mode and key. Both are decided on word 0 only; the very first
    // block after reset is always an init, whatever blk_first says.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_init_q <= 1'b0;
            core_key    <= '0;
        end else if (accept && (cnt_q == '0)) begin
            mode_init_q <= new_msg;
            if (new_msg) begin
                core_key <= key_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_ever_q <= 1'b1;
        end else if (launch) begin
            first_ever_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Tag capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_o       <= '0;
            tag_valid_o <= 1'b0;
        end else begin
            tag_valid_o <= capture;
            if (capture) begin
                tag_o <= core_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Launch pulses are exclusive and only ever seen while launching.
    // ------------------------------------------------------------------
    assert property (@(posedge clk) disable iff (reset) !(core_init && core_next));
    assert property (@(posedge clk) disable iff (reset)
                     (core_init || core_next) |-> (state_q == StLaunch));

endmodule

// File: tb/tb_hmac_block_driver.sv
module tb_hmac_block_driver;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 1024;
    localparam int KEY_W   = 384;
    localparam int TAG_W   = 384;
    localparam int WORDS   = 32;

    localparam logic [KEY_W-1:0] KEY_A5 = {12{32'hA5A5A5A5}};

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [KEY_W-1:0]   key_in = '0;
    logic               blk_first = 1'b0;
    logic               word_valid = 1'b0;
    logic               word_ready;
    logic [WORD_W-1:0]  word_data = '0;
    logic               clear = 1'b0;
    logic               busy;
    logic [TAG_W-1:0]   tag_o;
    logic               tag_valid_o;
    logic               core_init;
    logic               core_next;
    logic               core_ready = 1'b0;
    logic               core_tag_valid;
    logic [KEY_W-1:0]   core_key;
    logic [BLOCK_W-1:0] core_block;
    logic [TAG_W-1:0]   core_tag;

    always #5 clk = ~clk;

    hmac_block_driver #(
        .WORD_W (WORD_W),
        .BLOCK_W(BLOCK_W),
        .KEY_W  (KEY_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .blk_first     (blk_first),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .clear         (clear),
        .busy          (busy),
        .tag_o         (tag_o),
        .tag_valid_o   (tag_valid_o),
        .core_init     (core_init),
        .core_next     (core_next),
        .core_ready    (core_ready),
        .core_tag_valid(core_tag_valid),
        .core_key      (core_key),
        .core_block    (core_block),
        .core_tag      (core_tag)
    );

    int checks = 0;
    int errors = 0;
    int n_init = 0;
    int n_next = 0;
    int ready_mode = 1;   // 0 random, 1 always ready, 2 stalled

    // Stand-in for HMAC-384: any function of (chain, key, block, mode) that mixes all bits.
    function automatic logic [TAG_W-1:0] toy_tag(input logic [TAG_W-1:0] prev,
                                                 input logic [KEY_W-1:0] key,
                                                 input logic [BLOCK_W-1:0] blk,
                                                 input logic init);
        logic [TAG_W-1:0] base;
        base = init ? key : prev;
        return {base[TAG_W-2:0], base[TAG_W-1]} ^ blk[1023:640] ^ blk[639:256] ^
               {blk[255:0], blk[1023:896]} ^ {382'b0, init, ~init};
    endfunction

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [TAG_W-1:0] act,
                       input logic [TAG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BLOCK_W-1:0] act,
                           input logic [BLOCK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 3; i >= 0; i--) begin
                if (act[256*i +: 256] !== exp[256*i +: 256]) begin
                    $display("FAIL %s at %0t chunk %0d: got %0h expected %0h", name, $time, i,
                             act[256*i +: 256], exp[256*i +: 256]);
                    break;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Core model: on a launch, keep the old tag valid for a few cycles, drop it,
    // then present the new tag after a random latency.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] c_chain, c_pend;
    int               c_phase, c_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_tag_valid <= 1'b0;
            core_tag       <= '0;
            c_chain        <= '0;
            c_pend         <= '0;
            c_phase        <= 0;
            c_cnt          <= 0;
        end else if (core_init || core_next) begin
            c_chain <= toy_tag(c_chain, core_key, core_block, core_init);
            c_pend  <= toy_tag(c_chain, core_key, core_block, core_init);
            c_phase <= 1;
            c_cnt   <= int'($urandom_range(0, 2));
        end else if (c_phase == 1) begin
            if (c_cnt == 0) begin
                core_tag_valid <= 1'b0;
                c_phase        <= 2;
                c_cnt          <= int'($urandom_range(1, 5));
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else if (c_phase == 2) begin
            if (c_cnt == 0) begin
                core_tag_valid <= 1'b1;
                core_tag       <= c_pend;
                c_phase        <= 0;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) core_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 1) core_ready = 1'b1;
            else core_ready = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model, transaction level: collect 32 words, then one launch,
    // then a fresh tag once the core has dropped its previous one.
    // ------------------------------------------------------------------
    logic [31:0]      m_words [WORDS];
    int               m_cnt;
    logic             m_busy, m_launched, m_armed, m_first_ever, m_mode_init, m_tag_pulse;
    logic [KEY_W-1:0] m_key;
    logic [TAG_W-1:0] m_tag, m_exp_tag, m_chain;

    function automatic logic [BLOCK_W-1:0] pack_model();
        logic [BLOCK_W-1:0] p;
        for (int k = 0; k < WORDS; k++) p[BLOCK_W-1-32*k -: 32] = m_words[k];
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < WORDS; k++) m_words[k] = '0;
        m_cnt = 0;
        m_busy = 1'b0;
        m_launched = 1'b0;
        m_armed = 1'b0;
        m_first_ever = 1'b1;
        m_mode_init = 1'b0;
        m_tag_pulse = 1'b0;
        m_key = '0;
        m_tag = '0;
        m_exp_tag = '0;
        m_chain = '0;
    endtask

    task automatic model_step();
        m_tag_pulse = 1'b0;
        if (!m_busy) begin
            if (clear) begin
                m_cnt = 0;
            end else if (word_valid) begin
                if (m_cnt == 0) begin
                    m_mode_init = blk_first || m_first_ever;
                    if (m_mode_init) m_key = key_in;
                end
                m_words[m_cnt] = word_data;
                m_cnt++;
                if (m_cnt == WORDS) begin
                    m_cnt = 0;
                    m_busy = 1'b1;
                    m_launched = 1'b0;
                    m_armed = 1'b0;
                end
            end
        end else if (!m_launched) begin
            if (core_ready) begin
                m_launched = 1'b1;
                m_first_ever = 1'b0;
                m_exp_tag = toy_tag(m_chain, m_key, pack_model(), m_mode_init);
                m_chain = m_exp_tag;
            end
        end else if (!m_armed) begin
            if (!core_tag_valid) m_armed = 1'b1;
        end else if (core_tag_valid) begin
            m_tag = m_exp_tag;
            m_tag_pulse = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) model_reset();
            chk("word_ready", word_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("core_init", core_init, m_busy && !m_launched && core_ready && m_mode_init);
            chk("core_next", core_next, m_busy && !m_launched && core_ready && !m_mode_init);
            chk("tag_valid_o", tag_valid_o, m_tag_pulse);
            chk("tag_o", tag_o, m_tag);
            if (m_busy) begin
                chk_blk("core_block", core_block, pack_model());
                chk("core_key", core_key, m_key);
            end
            if (core_init) n_init++;
            if (core_next) n_next++;
            if (!reset) model_step();
        end
    end

    // ------------------------------------------------------------------
    // Host side
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic f, input logic [KEY_W-1:0] k);
        word_valid = 1'b1;
        word_data  = d;
        blk_first  = f;
        key_in     = k;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (word_ready) begin
                step();
                word_valid = 1'b0;
                return;
            end
            step();
        end
        chk("send_timeout", 1'b0, 1'b1);
        word_valid = 1'b0;
    endtask

    task automatic do_clear(input logic with_word);
        clear      = 1'b1;
        word_valid = with_word;
        word_data  = $urandom;
        step();
        clear      = 1'b0;
        word_valid = 1'b0;
    endtask

    // Returns at the negedge of the tag_valid_o cycle.
    task automatic wait_tag();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (tag_valid_o) return;
        end
        chk("tag_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [BLOCK_W-1:0] blk_lit;
        logic [TAG_W-1:0]   tag2;
        logic [KEY_W-1:0]   k;
        int                 i0, n0, nb, ncl, gap;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // T1 reset state
        @(negedge clk);
        chk("t1_word_ready", word_ready, 1'b1);
        chk("t1_busy", busy, 1'b0);
        chk("t1_tag_valid", tag_valid_o, 1'b0);
        chk("t1_core_init", core_init, 1'b0);
        chk("t1_core_next", core_next, 1'b0);
        step();

        // T2 single block
        ready_mode = 1;
        i0 = n_init; n0 = n_next;
        for (int w = 0; w < WORDS; w++) send_word(32'(w), 1'b1, KEY_A5);
        wait_tag();
        for (int w = 0; w < WORDS; w++) blk_lit[BLOCK_W-1-32*w -: 32] = 32'(w);
        chk("t2_blk_msw", core_block[1023:992], 32'h0);
        chk("t2_blk_lsw", core_block[31:0], 32'h1F);
        chk("t2_key", core_key, KEY_A5);
        chk("t2_inits", 32'(n_init - i0), 32'd1);
        chk("t2_nexts", 32'(n_next - n0), 32'd0);
        tag2 = toy_tag('0, KEY_A5, blk_lit, 1'b1);
        chk("t2_tag", tag_o, tag2);
        step();

        // T3 continuation block, key input changed but ignored
        i0 = n_init; n0 = n_next;
        for (int w = 0; w < WORDS; w++) send_word(32'h100 + 32'(w), 1'b0, '0);
        wait_tag();
        for (int w = 0; w < WORDS; w++) blk_lit[BLOCK_W-1-32*w -: 32] = 32'h100 + 32'(w);
        chk("t3_inits", 32'(n_init - i0), 32'd0);
        chk("t3_nexts", 32'(n_next - n0), 32'd1);
        chk("t3_key", core_key, KEY_A5);
        chk("t3_tag", tag_o, toy_tag(tag2, KEY_A5, blk_lit, 1'b0));
        step();

        // T4 next word held valid while the previous block is in flight
        i0 = n_init; n0 = n_next;
        k = rand_key();
        for (int w = 0; w < WORDS; w++) send_word(32'h400 + 32'(w), 1'b1, k);
        for (int w = 0; w < WORDS; w++) send_word(32'hDEAD0000 + 32'(w), 1'b0, rand_key());
        wait_tag();
        chk("t4_blk_msw", core_block[1023:992], 32'hDEAD0000);
        chk("t4_blk_lsw", core_block[31:0], 32'hDEAD001F);
        chk("t4_key", core_key, k);
        chk("t4_inits", 32'(n_init - i0), 32'd1);
        chk("t4_nexts", 32'(n_next - n0), 32'd1);
        step();

        // T5 clear mid-block, colliding with a valid word
        i0 = n_init; n0 = n_next;
        for (int w = 0; w < 10; w++) send_word(32'h500 + 32'(w), 1'b1, rand_key());
        do_clear(1'b1);
        for (int w = 0; w < WORDS - 1; w++) send_word(32'hFFFFFFFF, 1'b0, rand_key());
        @(negedge clk);
        chk("t5_no_early_launch", busy, 1'b0);
        step();
        send_word(32'hFFFFFFFF, 1'b0, rand_key());
        wait_tag();
        blk_lit = '1;
        chk_blk("t5_all_ones", core_block, blk_lit);
        chk("t5_nexts", 32'(n_next - n0), 32'd1);
        chk("t5_inits", 32'(n_init - i0), 32'd0);
        step();

        // T6 core stalls for 5 cycles at launch
        ready_mode = 2;
        step();
        i0 = n_init;
        for (int w = 0; w < WORDS; w++) send_word($urandom, 1'b1, rand_key());
        repeat (5) begin
            @(negedge clk);
            chk("t6_stall_no_init", core_init, 1'b0);
            chk("t6_stall_busy", busy, 1'b1);
        end
        @(posedge clk);
        ready_mode = 1;
        @(negedge clk);
        chk("t6_init_on_ready", core_init, 1'b1);
        wait_tag();
        chk("t6_inits", 32'(n_init - i0), 32'd1);
        step();

        // Reset mid-fill aborts; first block afterwards is an init even without blk_first
        ready_mode = 0;
        for (int w = 0; w < 15; w++) send_word($urandom, 1'b1, rand_key());
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_word_ready", word_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tag_o", tag_o, '0);
        step();
        i0 = n_init; n0 = n_next;
        k = rand_key();
        for (int w = 0; w < WORDS; w++) send_word($urandom, 1'b0, k);
        wait_tag();
        chk("rst_inits", 32'(n_init - i0), 32'd1);
        chk("rst_nexts", 32'(n_next - n0), 32'd0);
        chk("rst_key", core_key, k);
        step();

        // Randomized messages: gaps, stalls, clears, blk_first/key noise on later words
        for (int m = 0; m < 10; m++) begin
            k  = rand_key();
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ncl = int'($urandom_range(1, 20));
                    for (int w = 0; w < ncl; w++)
                        send_word($urandom, 1'($urandom_range(0, 1)), rand_key());
                    do_clear(1'($urandom_range(0, 1)));
                end
                for (int w = 0; w < WORDS; w++) begin
                    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    repeat (gap) step();
                    if (w == 0) send_word($urandom, (b == 0), k);
                    else send_word($urandom, 1'($urandom_range(0, 1)), rand_key());
                end
            end
        end
        wait_tag();
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
